trigger_pulse_gen: RTL

TRIGGER_PULSE_GEN -- requirements
Module: trigger_pulse_gen

---
 rtl/trigger_pkg.sv | 18 +
 rtl/trigger_edge_sync.sv | 43 ++++
 rtl/trigger_pulse_gen.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/trigger_pkg.sv
// Purpose : shared state encoding and default field widths for the trigger stages.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
package trigger_pkg;

   // Default width of the pulse_width / pulse_period configuration fields.
   localparam int unsigned COUNTER_WIDTH_DEF = 32;
   // Default width of the pulse_count field and of pulse_index.
   localparam int unsigned COUNT_WIDTH_DEF   = 8;

   // Pulse generator sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } trig_state_t;

endpackage

// File: rtl/trigger_edge_sync.sv
// Purpose : 2-flop synchroniser plus rising-edge detector for an asynchronous trigger level.
// Latency : rise is valid in the cycle after the 2nd clock edge that samples the input high.
// Backpr. : none; rise is a single-cycle strobe and must be consumed or dropped.
//
// Ports: clock, reset (sync, active-high), async_in (asynchronous level),
//        rise (one-cycle strobe on a synchronised low-to-high transition).
module trigger_edge_sync (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic       sync_meta;
   logic       sync_q;
   logic       sync_prev;
   logic [1:0] fill_q;
   logic       armed_q;

   // fill_q marks when sync_q carries a real post-reset sample; armed_q only
   // sets once that sample has been seen low, so a level already high when
   // reset releases never looks like an edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
         sync_prev <= 1'b0;
         fill_q    <= 2'b00;
         armed_q   <= 1'b0;
      end else begin
         sync_meta <= async_in;
         sync_q    <= sync_meta;
         sync_prev <= sync_q;
         fill_q    <= {fill_q[0], 1'b1};
         if (fill_q[1] && !sync_q) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign rise = armed_q & sync_q & ~sync_prev;

endmodule

// File: rtl/trigger_pulse_gen.sv
// Purpose : shapes a synchronised trigger edge into a burst of configurable pulses.
// Latency : pulse_out/busy rise 3 clock edges after delayed_trigger is first sampled high.
// Backpr. : none; edges arriving while busy are dropped and flagged on overrun.
//
// Ports: clock, reset (sync, active-high), enable (arm / abort), delayed_trigger
//        (async level), pulse_width / pulse_period / pulse_count (latched at
//        acceptance), pulse_out, busy, done (1-cycle strobe), pulse_index, overrun.
module trigger_pulse_gen
   import trigger_pkg::*;
#(
   parameter int unsigned counter_width = COUNTER_WIDTH_DEF,
   parameter int unsigned count_width   = COUNT_WIDTH_DEF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     delayed_trigger,
   input  logic [counter_width-1:0] pulse_width,
   input  logic [counter_width-1:0] pulse_period,
   input  logic [count_width-1:0]   pulse_count,
   output logic                     pulse_out,
   output logic                     busy,
   output logic                     done,
   output logic [count_width-1:0]   pulse_index,
   output logic                     overrun
);

   localparam logic [counter_width-1:0] CTR_ONE = counter_width'(1);
   localparam logic [count_width-1:0]   CNT_ONE = count_width'(1);

   trig_state_t              state_q;
   trig_state_t              state_nxt;
   logic                     trig_rise;
   logic                     accept;
   logic                     high_end;
   logic                     low_end;
   logic                     last_pulse;

   logic [counter_width-1:0] timer_q;
   logic [counter_width-1:0] width_q;
   logic [counter_width-1:0] low_q;
   logic [count_width-1:0]   last_idx_q;
   logic [count_width-1:0]   index_q;
   logic                     done_q;
   logic                     overrun_q;

   logic [counter_width-1:0] width_eff;
   logic [counter_width-1:0] low_eff;
   logic [count_width-1:0]   last_eff;

   trigger_edge_sync u_edge_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (delayed_trigger),
      .rise     (trig_rise)
   );

   // Effective burst shape: zero width/count behave as one, and the low gap
   // never collapses below a single cycle.
   assign width_eff = (pulse_width == '0) ? CTR_ONE : pulse_width;
   assign low_eff   = (pulse_period > width_eff) ? (pulse_period - width_eff) : CTR_ONE;
   assign last_eff  = (pulse_count == '0) ? '0 : (pulse_count - CNT_ONE);

   assign accept     = (state_q == IDLE) && enable && trig_rise;
   assign high_end   = (timer_q == (width_q - CTR_ONE));
   assign low_end    = (timer_q == (low_q - CTR_ONE));
   assign last_pulse = (index_q == last_idx_q);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic; enable low aborts straight to IDLE.
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_nxt = HIGH;
            end
         end
         HIGH: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (high_end) begin
               state_nxt = last_pulse ? IDLE : LOW;
            end
         end
         LOW: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (low_end) begin
               state_nxt = HIGH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Burst datapath: per-state cycle timer, latched shape, index and flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         timer_q    <= '0;
         width_q    <= '0;
         low_q      <= '0;
         last_idx_q <= '0;
         index_q    <= '0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         // Timer restarts on every state change and rests at zero in IDLE.
         if ((state_nxt != state_q) || (state_q == IDLE)) begin
            timer_q <= '0;
         end else begin
            timer_q <= timer_q + CTR_ONE;
         end

         if (accept) begin
            width_q    <= width_eff;
            low_q      <= low_eff;
            last_idx_q <= last_eff;
         end

         if ((state_nxt == IDLE) || accept) begin
            index_q <= '0;
         end else if ((state_q == LOW) && (state_nxt == HIGH)) begin
            index_q <= index_q + CNT_ONE;
         end

         // Only a normal end of the final pulse strobes done, never an abort.
         done_q <= (state_q == HIGH) && enable && high_end && last_pulse;

         if (!enable) begin
            overrun_q <= 1'b0;
         end else if (trig_rise && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
         end
      end
   end

   // Output decode, all driven from registers.
   always_comb begin
      pulse_out   = (state_q == HIGH);
      busy        = (state_q != IDLE);
      done        = done_q;
      pulse_index = index_q;
      overrun     = overrun_q;
   end

endmodule
